// File: rtl/lsu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : lsu_pkg                                                 |
// | Brief    : Shared types, funct3 codes, fault causes and helpers    |
// |            for the load/store sequencer.                           |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RESP  = 2'd2,
        FAULT = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] CAUSE_NONE       = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL    = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT    = 2'b11;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Low two funct3 bits encode access size for every legal code.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : lsu_if                                                  |
// | Brief    : Request/acknowledge data-memory bus of the sequencer.   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
interface lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : lsu_load_align                                          |
// | Brief    : Selects byte/half of a read word and sign/zero-extends. |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module lsu_load_align
    import lsu_pkg::*;
(
    input  wire logic [2:0]  funct3,
    input  wire logic [1:0]  byte_off,
    input  wire logic [31:0] word,
    output logic      [31:0] data
);

    logic [31:0] w_shifted;
    logic [15:0] w_half;

    always_comb begin
        w_shifted = word >> {byte_off, 3'b000};
        w_half    = byte_off[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_BU:   data = {24'd0, w_shifted[7:0]};
            F3_H:    data = {{16{w_half[15]}}, w_half};
            F3_HU:   data = {16'd0, w_half};
            default: data = word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : lsu_ctrl                                                |
// | Brief    : Load/store sequencer: turns a load/store intent into a  |
// |            req/ack memory transaction and stalls the core.         |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        MemRead,
    input  wire logic        MemWrite,
    input  wire logic [2:0]  funct3,
    input  wire logic [31:0] addr,
    input  wire logic [31:0] wdata,
    output logic             stall,
    output logic      [31:0] rdata_o,
    output logic             load_valid,
    output logic             fault,
    output logic      [1:0]  fault_cause,
    lsu_if.master            mem
);

    localparam logic [7:0] c_timeout = 8'(TIMEOUT_CYCLES);

    lsu_state_t  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        load_valid_q, load_valid_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] w_aligned;

    lsu_load_align u_align (
        .funct3   (f3_q),
        .byte_off (off_q),
        .word     (mem.mem_rdata),
        .data     (w_aligned)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        f3_d         = f3_q;
        off_d        = off_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_wdata_d  = mem_wdata_q;
        rdata_d      = rdata_q;
        cause_d      = cause_q;
        load_valid_d = 1'b0;
        fault_d      = 1'b0;
        stall        = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    stall = 1'b1;
                    if ((MemRead && MemWrite) || !f3_legal(MemWrite, funct3)) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                        cause_d = CAUSE_ILLEGAL;
                    end else if (f3_misaligned(funct3, addr[1:0])) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                        cause_d = CAUSE_MISALIGNED;
                    end else begin
                        state_d     = REQ;
                        cnt_d       = 8'd0;
                        f3_d        = funct3;
                        off_d       = addr[1:0];
                        mem_req_d   = 1'b1;
                        mem_we_d    = MemWrite;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_wstrb_d = MemWrite ? store_strb(funct3, addr[1:0]) : 4'b0000;
                        mem_wdata_d = MemWrite ? store_data(funct3, wdata) : 32'd0;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                // An ack on the final allowed cycle still completes the access.
                if (mem.mem_ack || (cnt_q + 8'd1 == c_timeout)) begin
                    if (mem.mem_ack) begin
                        state_d      = RESP;
                        load_valid_d = !mem_we_q;
                        if (!mem_we_q)
                            rdata_d = w_aligned;
                    end else begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                        cause_d = CAUSE_TIMEOUT;
                    end
                    cnt_d       = 8'd0;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 32'd0;
                    mem_wstrb_d = 4'b0000;
                    mem_wdata_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            f3_q         <= 3'd0;
            off_q        <= 2'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wstrb_q  <= 4'b0000;
            mem_wdata_q  <= 32'd0;
            rdata_q      <= 32'd0;
            load_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            cause_q      <= CAUSE_NONE;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_q      <= rdata_d;
            load_valid_q <= load_valid_d;
            fault_q      <= fault_d;
            cause_q      <= cause_d;
        end
    end

    assign rdata_o       = rdata_q;
    assign load_valid    = load_valid_q;
    assign fault         = fault_q;
    assign fault_cause   = cause_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wstrb = mem_wstrb_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire
